// File: rtl/pc_ctrl.sv
// Fetch-stage program-counter controller: IDLE/RUN/HALT sequencing, jumps, signed branches,
// call/return through a small return-address stack, stall, and sticky stack error flags.
module pc_ctrl #(
  parameter int unsigned        PC_W      = 16,
  parameter int unsigned        OFF_W     = 8,
  parameter int unsigned        DEPTH     = 4,
  parameter logic [PC_W-1:0]    HALT_ADDR = PC_W'(503),
  localparam int unsigned       SP_W      = $clog2(DEPTH + 1)
) (
  input  logic              CLK,
  input  logic              init_n,
  input  logic              start,
  input  logic [PC_W-1:0]   start_addr,
  input  logic              stall,
  input  logic [2:0]        op,
  input  logic [PC_W-1:0]   target,
  input  logic [OFF_W-1:0]  offset,
  output logic [PC_W-1:0]   PC,
  output logic              halt,
  output logic              running,
  output logic [SP_W-1:0]   sp,
  output logic              ovf,
  output logic              unf
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [2:0] OpJump   = 3'b001;
  localparam logic [2:0] OpBranch = 3'b010;
  localparam logic [2:0] OpCall   = 3'b011;
  localparam logic [2:0] OpRet    = 3'b100;
  localparam logic [2:0] OpHalt   = 3'b101;

  typedef enum logic [1:0] {StIdle, StRun, StHalt} state_e;

  state_e            state_q;
  logic [PC_W-1:0]   pc_q;
  logic [SP_W-1:0]   sp_q;
  logic              ovf_q;
  logic              unf_q;
  logic [PC_W-1:0]   stack_q [DEPTH];

  logic              active;
  logic              call_push;
  logic [PC_W-1:0]   pc_inc;
  logic [PC_W-1:0]   pc_branch;
  logic [SP_W-1:0]   sp_dec;
  logic [IDX_W-1:0]  push_idx;
  logic [IDX_W-1:0]  pop_idx;

  always_comb begin
    // A RUN cycle that actually executes op: not stalled and not parked on the halt address.
    active    = (state_q == StRun) && !stall && (pc_q != HALT_ADDR);
    call_push = active && (op == OpCall) && (sp_q != SP_W'(DEPTH));
    pc_inc    = pc_q + PC_W'(1);
    pc_branch = pc_q + {{(PC_W - OFF_W){offset[OFF_W-1]}}, offset};
    sp_dec    = sp_q - SP_W'(1);
    push_idx  = sp_q[IDX_W-1:0];
    pop_idx   = sp_dec[IDX_W-1:0];
  end

  always_ff @(posedge CLK or negedge init_n) begin
    if (!init_n) begin
      state_q <= StIdle;
      pc_q    <= '0;
      sp_q    <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StRun;
            pc_q    <= start_addr;
            sp_q    <= '0;
          end
        end
        StRun: begin
          if (!stall) begin
            if (pc_q == HALT_ADDR) begin
              state_q <= StHalt;
            end else begin
              case (op)
                OpHalt: state_q <= StHalt;
                OpCall: begin
                  if (sp_q == SP_W'(DEPTH)) begin
                    ovf_q   <= 1'b1;
                    state_q <= StHalt;
                  end else begin
                    sp_q <= sp_q + SP_W'(1);
                    pc_q <= target;
                  end
                end
                OpRet: begin
                  if (sp_q == '0) begin
                    unf_q   <= 1'b1;
                    state_q <= StHalt;
                  end else begin
                    sp_q <= sp_dec;
                    pc_q <= stack_q[pop_idx];
                  end
                end
                OpJump:   pc_q <= target;
                OpBranch: pc_q <= pc_branch;
                default:  pc_q <= pc_inc;
              endcase
            end
          end
        end
        StHalt: begin
          if (start) begin
            state_q <= StRun;
            pc_q    <= start_addr;
            sp_q    <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Stack contents need no reset; entries at or above sp are never read.
  always_ff @(posedge CLK) begin
    if (call_push) begin
      stack_q[push_idx] <= pc_inc;
    end
  end

  assign PC      = pc_q;
  assign halt    = (state_q == StHalt);
  assign running = (state_q == StRun);
  assign sp      = sp_q;
  assign ovf     = ovf_q;
  assign unf     = unf_q;

endmodule

// File: tb/tb_pc_ctrl.sv
// Self-checking bench for pc_ctrl: directed vector table, async-reset sequence, and a
// randomized run against a queue-based reference model.
module tb_pc_ctrl;

  localparam logic [2:0] NEXT = 3'd0, JUMP = 3'd1, BRANCH = 3'd2, CALL = 3'd3,
                         RET = 3'd4, HALTOP = 3'd5;

  logic        CLK = 1'b0;
  logic        init_n;
  logic        start;
  logic [15:0] start_addr;
  logic        stall;
  logic [2:0]  op;
  logic [15:0] target;
  logic [7:0]  offset;
  logic [15:0] PC;
  logic        halt;
  logic        running;
  logic [2:0]  sp;
  logic        ovf;
  logic        unf;

  pc_ctrl #(
    .PC_W      (16),
    .OFF_W     (8),
    .DEPTH     (4),
    .HALT_ADDR (16'd503)
  ) dut (
    .CLK        (CLK),
    .init_n     (init_n),
    .start      (start),
    .start_addr (start_addr),
    .stall      (stall),
    .op         (op),
    .target     (target),
    .offset     (offset),
    .PC         (PC),
    .halt       (halt),
    .running    (running),
    .sp         (sp),
    .ovf        (ovf),
    .unf        (unf)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: 0 = idle, 1 = run, 2 = halted; return stack kept as a queue.
  int          m_state;
  logic [15:0] m_pc;
  logic [15:0] m_stk[$];
  logic        m_ovf, m_unf;

  typedef struct {
    logic        start;
    logic [15:0] sa;
    logic        stall;
    logic [2:0]  op;
    logic [15:0] tgt;
    logic [7:0]  off;
    logic [15:0] pc;
    logic        halt;
    logic        run;
    logic [2:0]  sp;
    logic        ovf;
    logic        unf;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(logic st, logic [15:0] sa, logic sl, logic [2:0] o,
                              logic [15:0] tg, logic [7:0] of, logic [15:0] epc,
                              logic eh, logic er, logic [2:0] esp, logic eo, logic eu);
    vec_t v;
    v.start = st; v.sa = sa; v.stall = sl; v.op = o; v.tgt = tg; v.off = of;
    v.pc = epc; v.halt = eh; v.run = er; v.sp = esp; v.ovf = eo; v.unf = eu;
    tbl.push_back(v);
  endfunction

  function automatic logic [22:0] dut_vec();
    return {PC, halt, running, sp, ovf, unf};
  endfunction

  task automatic check(string name, logic [22:0] act, logic [22:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got pc/h/r/sp/o/u=%h required %h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_state = 0; m_pc = '0; m_stk.delete(); m_ovf = 1'b0; m_unf = 1'b0;
  endfunction

  // Applies the rules for one rising edge using the inputs currently driven.
  function automatic void model_step();
    if (m_state != 1) begin
      if (start) begin
        m_state = 1; m_pc = start_addr; m_stk.delete(); m_ovf = 1'b0; m_unf = 1'b0;
      end
    end else if (!stall) begin
      if (m_pc == 16'd503) m_state = 2;
      else if (op == HALTOP) m_state = 2;
      else if (op == CALL) begin
        if (m_stk.size() == 4) begin m_ovf = 1'b1; m_state = 2; end
        else begin m_stk.push_back(16'(int'(m_pc) + 1)); m_pc = target; end
      end else if (op == RET) begin
        if (m_stk.size() == 0) begin m_unf = 1'b1; m_state = 2; end
        else m_pc = m_stk.pop_back();
      end else if (op == JUMP) m_pc = target;
      else if (op == BRANCH) m_pc = 16'(int'(m_pc) + int'($signed(offset)));
      else m_pc = 16'(int'(m_pc) + 1);
    end
  endfunction

  function automatic logic [22:0] model_vec();
    return {m_pc, m_state == 2, m_state == 1, 3'(m_stk.size()), m_ovf, m_unf};
  endfunction

  task automatic step(string name);
    model_step();
    @(posedge CLK);
    #1;
    check(name, dut_vec(), model_vec());
  endtask

  task automatic drive(logic st, logic [15:0] sa, logic sl, logic [2:0] o,
                       logic [15:0] tg, logic [7:0] of);
    start = st; start_addr = sa; stall = sl; op = o; target = tg; offset = of;
  endtask

  initial begin
    init_n = 1'b0;
    drive(0, 0, 0, NEXT, 0, 0);
    model_reset();

    // start, sa, stall, op, target, offset -> pc, halt, run, sp, ovf, unf
    add(1, 16'h0010, 0, NEXT,   0, 0,        16'h0010, 0, 1, 0, 0, 0);
    add(0, 0,        0, NEXT,   0, 0,        16'h0011, 0, 1, 0, 0, 0);
    add(0, 0,        0, NEXT,   0, 0,        16'h0012, 0, 1, 0, 0, 0);
    add(0, 0,        0, NEXT,   0, 0,        16'h0013, 0, 1, 0, 0, 0);
    add(0, 0,        0, JUMP,   16'h0020, 0, 16'h0020, 0, 1, 0, 0, 0);
    add(0, 0,        0, CALL,   16'h0100, 0, 16'h0100, 0, 1, 1, 0, 0);
    add(0, 0,        0, CALL,   16'h0200, 0, 16'h0200, 0, 1, 2, 0, 0);
    add(0, 0,        0, RET,    0, 0,        16'h0101, 0, 1, 1, 0, 0);
    add(0, 0,        0, RET,    0, 0,        16'h0021, 0, 1, 0, 0, 0);
    add(0, 0,        0, JUMP,   16'h0002, 0, 16'h0002, 0, 1, 0, 0, 0);
    add(0, 0,        0, BRANCH, 0, 8'hFC,    16'hFFFE, 0, 1, 0, 0, 0);
    add(0, 0,        0, NEXT,   0, 0,        16'hFFFF, 0, 1, 0, 0, 0);
    add(0, 0,        0, NEXT,   0, 0,        16'h0000, 0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) add(0, 0, 1, JUMP, 16'h0300, 0, 16'h0000, 0, 1, 0, 0, 0);
    add(0, 0,        0, JUMP,   16'h0300, 0, 16'h0300, 0, 1, 0, 0, 0);
    add(0, 0,        0, JUMP,   16'h01F5, 0, 16'h01F5, 0, 1, 0, 0, 0);
    add(0, 0,        0, NEXT,   0, 0,        16'h01F6, 0, 1, 0, 0, 0);
    add(0, 0,        0, NEXT,   0, 0,        16'h01F7, 0, 1, 0, 0, 0);
    add(0, 0,        0, JUMP,   16'h0400, 0, 16'h01F7, 1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) add(0, 0, 0, NEXT, 0, 0, 16'h01F7, 1, 0, 0, 0, 0);
    add(1, 16'h0000, 0, NEXT,   0, 0,        16'h0000, 0, 1, 0, 0, 0);
    add(0, 0,        0, RET,    0, 0,        16'h0000, 1, 0, 0, 0, 1);
    add(1, 16'h0040, 0, NEXT,   0, 0,        16'h0040, 0, 1, 0, 0, 0);
    for (int i = 1; i <= 4; i++) add(0, 0, 0, CALL, 16'h0050, 0, 16'h0050, 0, 1, 3'(i), 0, 0);
    add(0, 0,        0, CALL,   16'h0060, 0, 16'h0050, 1, 0, 4, 1, 0);
    add(1, 16'h0070, 0, NEXT,   0, 0,        16'h0070, 0, 1, 0, 0, 0);
    add(1, 16'h0999, 0, NEXT,   0, 0,        16'h0071, 0, 1, 0, 0, 0);
    add(0, 0,        0, HALTOP, 0, 0,        16'h0071, 1, 0, 0, 0, 0);
    add(0, 0,        0, 3'd6,   0, 0,        16'h0071, 1, 0, 0, 0, 0);
    add(1, 16'h1234, 1, NEXT,   0, 0,        16'h1234, 0, 1, 0, 0, 0);
    add(0, 0,        0, 3'd7,   0, 0,        16'h1235, 0, 1, 0, 0, 0);

    #12;
    check("reset_values", dut_vec(), 23'h0);
    init_n = 1'b1;
    step("idle_hold");

    foreach (tbl[i]) begin
      drive(tbl[i].start, tbl[i].sa, tbl[i].stall, tbl[i].op, tbl[i].tgt, tbl[i].off);
      step($sformatf("model_vec%0d", i));
      check($sformatf("vec%0d", i), dut_vec(),
            {tbl[i].pc, tbl[i].halt, tbl[i].run, tbl[i].sp, tbl[i].ovf, tbl[i].unf});
    end

    // Asynchronous reset mid-RUN, observed before any clock edge.
    drive(0, 0, 0, JUMP, 16'h0300, 0);
    #2;
    init_n = 1'b0;
    #1;
    check("async_reset", dut_vec(), 23'h0);
    model_reset();
    #1;
    init_n = 1'b1;
    step("idle_after_reset");
    check("idle_ignores_op", dut_vec(), 23'h0);

    for (int i = 0; i < 3000; i++) begin
      logic [15:0] tg;
      tg = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(490, 503)) : 16'($urandom);
      drive($urandom_range(0, 15) == 0,
            ($urandom_range(0, 3) == 0) ? 16'($urandom_range(495, 503)) : 16'($urandom),
            $urandom_range(0, 7) == 0, 3'($urandom), tg, 8'($urandom));
      step("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
